// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path (uart_receiver and uart_rx_fifo).
package uart_rx_pkg;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  localparam int MIN_CLKS_PER_BIT = 8;

  function automatic int calc_clks_per_bit(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular first-word fall-through byte FIFO for the UART receiver (used with UART_RX_FIFO_EN).
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Pointer MSB toggles on each wrap, so equal indices with differing MSBs means full.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with sticky error flags. Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry
// buffer; otherwise a single holding register buffers one byte.
module uart_receiver
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 9600,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_baud
    $error("uart_receiver: CLKS_PER_BIT below minimum");
  end

  logic [1:0]       sync_q;
  logic             rxs;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             push;
  logic             ferr_set;
  logic             full;
  logic             ovr_set;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], rxd};
  end
  assign rxs = sync_q[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = RX_START;
      end
      RX_START: begin
        bit_d = '0;
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = rxs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // Leave at the stop-bit centre so the next start edge is not missed.
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (rxs) begin
            push    = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = RX_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  assign rx_busy = (state_q != RX_IDLE);

`ifdef UART_RX_FIFO_EN
  logic empty;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_receiver: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push),
    .pop     (rd_en),
    .wr_data (shift_q),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );
  assign rx_valid = !empty;
`else
  logic [7:0] hold_q;
  logic       hold_v;
  logic       hold_pop;
  logic       hold_acc;
  logic       unused_fifo_depth;

  assign unused_fifo_depth = ^FIFO_DEPTH;
  assign hold_pop = rd_en && hold_v;
  assign hold_acc = push && (!hold_v || hold_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q <= '0;
      hold_v <= 1'b0;
    end else if (hold_acc) begin
      hold_q <= shift_q;
      hold_v <= 1'b1;
    end else if (hold_pop) begin
      hold_q <= '0;
      hold_v <= 1'b0;
    end
  end

  assign full     = hold_v;
  assign rd_data  = hold_q;
  assign rx_valid = hold_v;
`endif

  // A pop in the same cycle frees a slot, so only an unserviced full buffer drops a byte.
  assign ovr_set = push && full && !rd_en;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_set)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (ovr_set)      overrun   <= 1'b1;
      else if (clr_err) overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 12 clocks per bit with a FIFO_DEPTH of 4.
module tb_uart_receiver;

  localparam int CLK_FREQ_HZ = 12000000;
  localparam int BAUD_RATE   = 1000000;
  localparam int FIFO_DEPTH  = 4;
  localparam int CPB         = 12;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk     = 1'b0;
  logic       resetn  = 1'b0;
  logic       rxd     = 1'b1;
  logic       rd_en   = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic       valid_pre;
  logic       valid_post;
  logic [7:0] head_at_stop;

  uart_receiver #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD_RATE   (BAUD_RATE),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rxd       (rxd),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rd_data   (rd_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; the stop sample lands between stop-bit cycles 8 and 9.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic pop_at_stop);
    rxd = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      cycles(CPB);
    end
    rxd = stop_bit;
    for (int i = 0; i < CPB; i++) begin
      if (i == 8) begin
        valid_pre    = rx_valid;
        head_at_stop = rd_data;
        rd_en        = pop_at_stop;
      end
      if (i == 9) begin
        valid_post = rx_valid;
        rd_en      = 1'b0;
      end
      @(negedge clk);
    end
    rxd = stop_bit;
  endtask

  task automatic drain(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, rx_valid, 8'd1);
      check({tag, "_data"}, rd_data, e);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    check({tag, "_empty_valid"}, rx_valid, 8'd0);
    check({tag, "_empty_data"}, rd_data, 8'h00);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_data"}, rd_data, 8'h00);
    check({tag, "_rx_valid"}, rx_valid, 8'd0);
    check({tag, "_frame_err"}, frame_err, 8'd0);
    check({tag, "_overrun"}, overrun, 8'd0);
    check({tag, "_rx_busy"}, rx_busy, 8'd0);
  endtask

  initial begin
    int n;
    cycles(3);
    check_reset_outputs("reset");
    resetn = 1'b1;
    cycles(5);

    // 1: single byte, valid timing, pop
    send_frame(8'hA5, 1'b1, 1'b0);
    exp_q.push_back(8'hA5);
    check("t1_valid_before_stop", valid_pre, 8'd0);
    check("t1_valid_after_stop", valid_post, 8'd1);
    drain("t1");

    // 2: overflow
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      if (i <= DEPTH) exp_q.push_back(8'(i));
    end
    check("t2_overrun", overrun, 8'd1);
    check("t2_frame_err", frame_err, 8'd0);
    drain("t2");
    pulse_clr();
    check("t2_overrun_clr", overrun, 8'd0);

    // 3: framing error with held-low line
    send_frame(8'h3C, 1'b0, 1'b0);
    check("t3_frame_err", frame_err, 8'd1);
    check("t3_valid", rx_valid, 8'd0);
    check("t3_busy_break", rx_busy, 8'd1);
    pulse_clr();
    cycles(29 * CPB - 1);
    check("t3_single_err", frame_err, 8'd0);
    check("t3_valid_hold", rx_valid, 8'd0);
    rxd = 1'b1;
    cycles(5);
    check("t3_busy_release", rx_busy, 8'd0);
    send_frame(8'h42, 1'b1, 1'b0);
    exp_q.push_back(8'h42);
    drain("t3");
    check("t3_frame_err_after", frame_err, 8'd0);

    // 4: short glitch is a false start
    rxd = 1'b0;
    cycles(4);
    check("t4_busy_glitch", rx_busy, 8'd1);
    rxd = 1'b1;
    n = 0;
    while (rx_busy && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("t4_busy_drop", rx_busy, 8'd0);
    cycles(20);
    check("t4_valid", rx_valid, 8'd0);
    check("t4_frame_err", frame_err, 8'd0);
    check("t4_overrun", overrun, 8'd0);

    // 5: reset in the middle of bit 4, with a byte already buffered
    send_frame(8'h11, 1'b1, 1'b0);
    rxd = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = (i == 0) ? 1'b0 : 1'b1;
      cycles(CPB);
    end
    rxd = 1'b1;
    cycles(CPB / 2);
    check("t5_busy_pre", rx_busy, 8'd1);
    check("t5_valid_pre", rx_valid, 8'd1);
    resetn = 1'b0;
    cycles(2);
    check_reset_outputs("t5_reset");
    resetn = 1'b1;
    cycles(3);
    send_frame(8'h7E, 1'b1, 1'b0);
    exp_q.push_back(8'h7E);
    drain("t5");

    // 6: pop on the exact cycle of a push into a full buffer
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'h90 + 8'(i), 1'b1, 1'b0);
      exp_q.push_back(8'h90 + 8'(i));
    end
    send_frame(8'h99, 1'b1, 1'b1);
    check("t6_head_popped", head_at_stop, exp_q.pop_front());
    exp_q.push_back(8'h99);
    check("t6_overrun", overrun, 8'd0);
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
